cart_mapper: RTL

CART_MAPPER -- requirements
Module: cart_mapper

---
 rtl/cart_mapper_if.sv | 12 +
 rtl/cart_mapper.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cart_mapper_if.sv
// CPU-side cartridge bus plus the registered ROM-read address returned to the cart RAM.
interface cart_mapper_if;
    logic [15:0] addr;
    logic        wr;
    logic        SLTSL_n;
    logic [7:0]  d_from_cpu;
    logic [24:0] mem_addr;
    logic        mem_oe;

    modport master (output addr, wr, SLTSL_n, d_from_cpu, input mem_addr, mem_oe);
    modport slave  (input addr, wr, SLTSL_n, d_from_cpu, output mem_addr, mem_oe);
endinterface

// File: rtl/cart_mapper.sv
// MSX cartridge mapper: bank switching for Konami, Konami SCC, ASCII8 and ASCII16.
// Translates CPU addresses into masked ROM byte addresses, with one cycle of latency.
// Unknown, GameMaster2 and reserved mapper codes fall back to a plain offset window.
module cart_mapper (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mapper,
    input  logic [3:0]  offset,
    input  logic [24:0] rom_size,
    input  logic        ioctl_isROM,
    cart_mapper_if.slave bus
);
    localparam logic [2:0] M_NONE    = 3'd1;
    localparam logic [2:0] M_KONAMI  = 3'd3;
    localparam logic [2:0] M_SCC     = 3'd4;
    localparam logic [2:0] M_ASCII8  = 3'd5;
    localparam logic [2:0] M_ASCII16 = 3'd6;

    logic [2:0]      eff_mapper;
    logic [2:0]      mapper_q;
    logic            sel;
    logic            wr_q;
    logic            wr_edge;
    logic [3:0][7:0] bank;
    logic [3:0][7:0] bank_dflt;
    logic            bank_hit;
    logic [1:0]      bank_idx;
    logic [1:0]      region;
    logic [24:0]     raw;
    logic            in_window;
    logic            oe_c;
    logic [24:0]     rom_m1;
    logic [24:0]     size_mask_c;
    logic [24:0]     size_mask;
    logic [24:0]     mem_addr_q;
    logic            mem_oe_q;

    assign sel     = ~bus.SLTSL_n & ~ioctl_isROM;
    assign wr_edge = bus.wr & sel & ~wr_q;
    // 8 KB window slot: 4000->0, 6000->1, 8000->2, A000->3
    assign region  = bus.addr[14:13] - 2'd2;
    assign oe_c    = sel & ~bus.wr & in_window;

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_oe   = mem_oe_q;

    // Fold the codes without a bank scheme onto the plain offset mapping
    always_comb begin
        eff_mapper = M_NONE;
        case (mapper)
            M_KONAMI, M_SCC, M_ASCII8, M_ASCII16: eff_mapper = mapper;
            default:                              eff_mapper = M_NONE;
        endcase
    end

    // Power-up/switch bank contents for the incoming mapper
    always_comb begin
        bank_dflt = '0;
        if (eff_mapper == M_KONAMI || eff_mapper == M_SCC)
            bank_dflt = {8'd3, 8'd2, 8'd1, 8'd0};
    end

    // Which bank register, if any, a CPU write targets
    always_comb begin
        bank_hit = 1'b0;
        bank_idx = 2'd0;
        case (eff_mapper)
            M_KONAMI: begin
                case (bus.addr[15:13])
                    3'd3: begin bank_hit = 1'b1; bank_idx = 2'd1; end
                    3'd4: begin bank_hit = 1'b1; bank_idx = 2'd2; end
                    3'd5: begin bank_hit = 1'b1; bank_idx = 2'd3; end
                    default: ;
                endcase
            end
            M_SCC: begin
                case (bus.addr[15:11])
                    5'h0A: begin bank_hit = 1'b1; bank_idx = 2'd0; end
                    5'h0E: begin bank_hit = 1'b1; bank_idx = 2'd1; end
                    5'h12: begin bank_hit = 1'b1; bank_idx = 2'd2; end
                    5'h16: begin bank_hit = 1'b1; bank_idx = 2'd3; end
                    default: ;
                endcase
            end
            M_ASCII8: begin
                if (bus.addr[15:13] == 3'd3) begin
                    bank_hit = 1'b1;
                    bank_idx = bus.addr[12:11];
                end
            end
            M_ASCII16: begin
                case (bus.addr[15:11])
                    5'h0C: begin bank_hit = 1'b1; bank_idx = 2'd0; end
                    5'h0E: begin bank_hit = 1'b1; bank_idx = 2'd1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // CPU address to unmasked ROM offset, using the banks as they stand before any write
    always_comb begin
        in_window = 1'b0;
        raw       = '0;
        case (eff_mapper)
            M_KONAMI, M_SCC, M_ASCII8: begin
                in_window = (bus.addr[15:14] == 2'b01) || (bus.addr[15:14] == 2'b10);
                raw       = {4'd0, bank[region], bus.addr[12:0]};
            end
            M_ASCII16: begin
                in_window = (bus.addr[15:14] == 2'b01) || (bus.addr[15:14] == 2'b10);
                raw       = {3'd0, bank[{1'b0, bus.addr[15]}], bus.addr[13:0]};
            end
            default: begin
                in_window = 1'b1;
                raw       = {9'd0, bus.addr} - {9'd0, offset, 12'd0};
            end
        endcase
    end

    // Mask = next power of two minus one; size 0 wraps to all ones
    always_comb begin
        rom_m1      = rom_size - 25'd1;
        size_mask_c = '0;
        for (int i = 0; i < 25; i++)
            size_mask_c[i] = |(rom_m1 >> i);
    end

    // Size mask tracks rom_size one cycle behind, independent of reset
    always_ff @(posedge clk) begin
        size_mask <= size_mask_c;
    end

    // Bank state: reset and mapper switches load defaults, else first cycle of a write updates
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q     <= 1'b0;
            mapper_q <= mapper;
            bank     <= bank_dflt;
        end else begin
            wr_q     <= bus.wr & sel;
            mapper_q <= mapper;
            if (ioctl_isROM || (mapper != mapper_q))
                bank <= bank_dflt;
            else if (wr_edge && bank_hit)
                bank[bank_idx] <= bus.d_from_cpu;
        end
    end

    // Registered read address, forced to zero whenever no valid read is presented
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q <= '0;
            mem_oe_q   <= 1'b0;
        end else begin
            mem_oe_q   <= oe_c;
            mem_addr_q <= oe_c ? (raw & size_mask) : 25'd0;
        end
    end
endmodule
